// File: rtl/pwm_seq_pkg.sv
// pwm_seq_pkg: shared widths, ramp state encoding and saturating step helper
package pwm_seq_pkg;
  localparam int DEF_DUTY_W = 8;
  localparam int DEF_RATE_W = 4;
  localparam int DEF_STEP_W = 4;
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  function automatic state_t dir_of(input logic [DEF_DUTY_W-1:0] cur, input logic [DEF_DUTY_W-1:0] tgt);
    return (cur < tgt) ? UP : (cur > tgt) ? DOWN : IDLE;
  endfunction
  function automatic logic [DEF_DUTY_W-1:0] sat_step(input logic [DEF_DUTY_W-1:0] cur,
                                                    input logic [DEF_DUTY_W-1:0] tgt,
                                                    input logic [DEF_STEP_W-1:0] step);
    logic [DEF_DUTY_W:0] sum;
    logic [DEF_DUTY_W:0] dif;
    sum = {1'b0, cur} + {{(DEF_DUTY_W+1-DEF_STEP_W){1'b0}}, step};
    dif = {1'b0, cur} - {{(DEF_DUTY_W+1-DEF_STEP_W){1'b0}}, step};
    if (step == '0) return tgt;
    if (cur < tgt) return (sum >= {1'b0, tgt}) ? tgt : sum[DEF_DUTY_W-1:0];
    if (cur > tgt) return (dif[DEF_DUTY_W] || dif[DEF_DUTY_W-1:0] <= tgt) ? tgt : dif[DEF_DUTY_W-1:0];
    return cur;
  endfunction
endpackage

// File: rtl/pwm_seq_gamma.sv
// pwm_seq_gamma: registered squarer giving a perceptual (gamma ~2) duty curve
module pwm_seq_gamma #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);
  logic [2*W-1:0] xw;
  logic [2*W-1:0] sq;
  assign xw = {{W{1'b0}}, x_i};
  assign sq = xw * xw;
  // keep the upper half of the square so full scale maps just below full scale
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) y_o <= '0;
    else y_o <= sq[2*W-1:W];
endmodule

// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: ramps the PWM duty toward a target at period boundaries; PWM_SEQ_GAMMA_EN adds a squared output curve
module pwm_duty_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int DUTY_W = DEF_DUTY_W,
  parameter int RATE_W = DEF_RATE_W,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DUTY_W-1:0] target_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [RATE_W-1:0] rate_i,
  input  logic              period_end_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic              duty_valid_o,
  output logic              busy_o,
  output logic              done_o
);
  state_t            state_q, state_d;
  logic [RATE_W-1:0] pcnt_q, pcnt_d;
  logic [DUTY_W-1:0] cur_q, cur_d;
  logic              ramping, tick, valid_d, done_d, valid_q, done_q;
  // direction comes straight from the live target so mid-ramp changes act on the next tick
  always_comb begin
    ramping = target_i != cur_q;
    tick    = ena && period_end_i && ramping && pcnt_q == rate_i;
    cur_d   = tick ? sat_step(cur_q, target_i, step_i) : cur_q;
    pcnt_d  = !ena ? pcnt_q : !ramping ? '0 : !period_end_i ? pcnt_q :
              (pcnt_q >= rate_i) ? '0 : pcnt_q + RATE_W'(1);
    state_d = !ena ? state_q : dir_of(cur_d, target_i);
    valid_d = tick && cur_d != cur_q;
    done_d  = tick && cur_d == target_i;
  end
  // state, period counter, current duty and event pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      cur_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      cur_q   <= cur_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
`ifdef PWM_SEQ_GAMMA_EN
  logic valid_g, done_g, busy_g;
  pwm_seq_gamma #(.W(DUTY_W)) u_gamma (
    .clk   (clk),
    .rst_n (rst_n),
    .x_i   (cur_q),
    .y_o   (duty_o)
  );
  // realign the status pulses with the extra squarer stage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_g <= 1'b0;
      done_g  <= 1'b0;
      busy_g  <= 1'b0;
    end else begin
      valid_g <= valid_q;
      done_g  <= done_q;
      busy_g  <= state_q != IDLE;
    end
  assign duty_valid_o = valid_g;
  assign done_o       = done_g;
  assign busy_o       = busy_g;
`else
  assign duty_o       = cur_q;
  assign duty_valid_o = valid_q;
  assign done_o       = done_q;
  assign busy_o       = state_q != IDLE;
`endif
endmodule
